code_select_sequencer: RTL and testbench

//   Downstream stage of the 7-to-3 encoder. It registers the encoder's combinational
//   3-bit code and filters out glitches and short-lived requests. A code that stays

---
 rtl/enc_mux_pkg.sv | 27 ++
 rtl/stability_filter.sv | 85 ++++++++
 rtl/code_select_sequencer.sv | 153 +++++++++++++++
 tb/tb_code_select_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/enc_mux_pkg.sv
// Shared definitions for the encoder -> select sequencer -> mux path.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package enc_mux_pkg;

  // Width of the encoder code and of the mux select.
  localparam int CODE_W = 3;

  // Code value that means "no request".
  localparam logic [CODE_W-1:0] IDLE_CODE = '0;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILTER = 2'd1,
    OFFER  = 2'd2,
    HOLD   = 2'd3
  } state_e;

  // Width of a down/up counter that must hold values 0..max(a,b) without wrapping.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/stability_filter.sv
// Registers the raw encoder code and qualifies a nonzero code that persists.
// Latency: stable pulse STABLE_CYCLES-1 cycles after entering FILTER (code_q registered 1 cycle).
// Backpressure: none; the owning FSM gates it through i_in_idle / i_in_filter.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   i_code            raw encoder code (may glitch)
//   i_in_idle         owning FSM is in IDLE: a nonzero code_q starts a candidate
//   i_in_filter       owning FSM is in FILTER: candidate is counted / restarted
//   o_code_q          registered copy of i_code
//   o_stable_pulse    one-cycle pulse: candidate persisted STABLE_CYCLES cycles
//   o_stable_code     the candidate code (valid with o_stable_pulse)
module stability_filter
  import enc_mux_pkg::*;
#(
  parameter int CODE_W        = 3,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] i_code,
  input  logic              i_in_idle,
  input  logic              i_in_filter,
  output logic [CODE_W-1:0] o_code_q,
  output logic              o_stable_pulse,
  output logic [CODE_W-1:0] o_stable_code
);

  localparam logic [CODE_W-1:0] NO_REQ    = CODE_W'(IDLE_CODE);
  localparam logic [CNT_W-1:0]  STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  logic [CODE_W-1:0] r_code_q;
  logic [CODE_W-1:0] r_cand;
  logic [CNT_W-1:0]  r_stab_cnt;

  logic w_code_nz;
  logic w_match;
  logic w_at_last;

  assign w_code_nz = (r_code_q != NO_REQ);
  assign w_match   = (r_code_q == r_cand);
  assign w_at_last = (r_stab_cnt == STAB_LAST);

  // The IDLE cycle that captures the candidate counts as its first stable
  // cycle, so the pulse fires when the count reaches STABLE_CYCLES-1.
  assign o_stable_pulse = i_in_filter & w_code_nz & w_match & w_at_last;
  assign o_stable_code  = r_cand;
  assign o_code_q       = r_code_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code_q   <= '0;
      r_cand     <= '0;
      r_stab_cnt <= '0;
    end else begin
      r_code_q <= i_code;
      if (i_in_idle) begin
        if (w_code_nz) begin
          r_cand     <= r_code_q;
          r_stab_cnt <= CNT_ONE;
        end else begin
          r_stab_cnt <= '0;
        end
      end else if (i_in_filter) begin
        if (!w_code_nz) begin
          r_stab_cnt <= '0;
        end else if (!w_match) begin
          // A different nonzero code restarts qualification from scratch.
          r_cand     <= r_code_q;
          r_stab_cnt <= CNT_ONE;
        end else if (!w_at_last) begin
          r_stab_cnt <= r_stab_cnt + CNT_ONE;
        end else begin
          r_stab_cnt <= '0;
        end
      end else begin
        // OFFER/HOLD: input is ignored for selection.
        r_stab_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/code_select_sequencer.sv
// Debounces the encoder code, offers a stable select to the mux, then holds it for a dwell time.
// Latency: code held from edge t -> sel_valid at edge t+1+STABLE_CYCLES; sel_active lasts DWELL_CYCLES.
// Backpressure: sel_valid stays up indefinitely until sel_ready; requests seen meanwhile are counted as drops.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   code_in      encoder output, may change every cycle
//   sel_ready    mux accepts the offered select
//   sel          latched select, stable while sel_valid|sel_active, kept until next offer
//   sel_valid    select offered (OFFER)
//   sel_active   select in use by the mux (HOLD)
//   busy         state != IDLE
//   drop_cnt     saturating count of new requests missed during OFFER/HOLD
module code_select_sequencer
  import enc_mux_pkg::*;
#(
  parameter int CODE_W        = 3,
  parameter int STABLE_CYCLES = 4,
  parameter int DWELL_CYCLES  = 8,
  parameter int DROP_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] code_in,
  input  logic              sel_ready,
  output logic [CODE_W-1:0] sel,
  output logic              sel_valid,
  output logic              sel_active,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int                CNT_W      = cnt_width(STABLE_CYCLES, DWELL_CYCLES);
  localparam logic [CODE_W-1:0] NO_REQ     = CODE_W'(IDLE_CODE);
  localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [DROP_W-1:0] DROP_ONE   = DROP_W'(1);

  state_e            r_state;
  logic [CODE_W-1:0] r_sel;
  logic              r_sel_valid;
  logic              r_sel_active;
  logic              r_busy;
  logic [CNT_W-1:0]  r_dwell_cnt;
  logic [CODE_W-1:0] r_code_qq;
  logic [DROP_W-1:0] r_drop_cnt;

  logic [CODE_W-1:0] w_code_q;
  logic              w_stable;
  logic [CODE_W-1:0] w_stable_code;
  logic              w_in_idle;
  logic              w_in_filter;
  logic              w_drop;

  assign w_in_idle   = (r_state == IDLE);
  assign w_in_filter = (r_state == FILTER);

  stability_filter #(
    .CODE_W        (CODE_W),
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_filter (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_code         (code_in),
    .i_in_idle      (w_in_idle),
    .i_in_filter    (w_in_filter),
    .o_code_q       (w_code_q),
    .o_stable_pulse (w_stable),
    .o_stable_code  (w_stable_code)
  );

  // Outputs are updated on the same edge as the state, so they are pure
  // registered decodes and sel_valid/sel_active can never overlap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_sel        <= '0;
      r_sel_valid  <= 1'b0;
      r_sel_active <= 1'b0;
      r_busy       <= 1'b0;
      r_dwell_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_code_q != NO_REQ) begin
            r_state <= FILTER;
            r_busy  <= 1'b1;
          end
        end
        FILTER: begin
          if (w_stable) begin
            r_state     <= OFFER;
            r_sel       <= w_stable_code;
            r_sel_valid <= 1'b1;
          end else if (w_code_q == NO_REQ) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        OFFER: begin
          if (sel_ready) begin
            r_state      <= HOLD;
            r_sel_valid  <= 1'b0;
            r_sel_active <= 1'b1;
            r_dwell_cnt  <= DWELL_LAST;
          end
        end
        HOLD: begin
          if (r_dwell_cnt == '0) begin
            r_state      <= IDLE;
            r_sel_active <= 1'b0;
            r_busy       <= 1'b0;
          end else begin
            r_dwell_cnt <= r_dwell_cnt - CNT_ONE;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_sel_valid  <= 1'b0;
          r_sel_active <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  // A drop is a fresh nonzero code (changed since last cycle) that differs
  // from the select currently owned by the mux path.
  assign w_drop = ((r_state == OFFER) || (r_state == HOLD)) &&
                  (w_code_q != r_code_qq) &&
                  (w_code_q != NO_REQ) &&
                  (w_code_q != r_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code_qq  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_code_qq <= w_code_q;
      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + DROP_ONE;
      end
    end
  end

  assign sel        = r_sel;
  assign sel_valid  = r_sel_valid;
  assign sel_active = r_sel_active;
  assign busy       = r_busy;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_code_select_sequencer.sv
// Directed bench for code_select_sequencer (STABLE_CYCLES=4, DWELL_CYCLES=8).
// Inputs are driven 1ns after a rising edge; outputs are sampled at the same point.
// Expected values are hand-derived cycle counts and constants.
module tb_code_select_sequencer;

  localparam int CODE_W        = 3;
  localparam int STABLE_CYCLES = 4;
  localparam int DWELL_CYCLES  = 8;
  localparam int DROP_W        = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [CODE_W-1:0] code_in = '0;
  logic              sel_ready = 1'b0;
  logic [CODE_W-1:0] sel;
  logic              sel_valid;
  logic              sel_active;
  logic              busy;
  logic [DROP_W-1:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  code_select_sequencer #(
    .CODE_W        (CODE_W),
    .STABLE_CYCLES (STABLE_CYCLES),
    .DWELL_CYCLES  (DWELL_CYCLES),
    .DROP_W        (DROP_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_in    (code_in),
    .sel_ready  (sel_ready),
    .sel        (sel),
    .sel_valid  (sel_valid),
    .sel_active (sel_active),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset for 3 cycles; all outputs must be zero.
  task automatic test_reset();
    rst_n = 1'b0;
    code_in = '0;
    sel_ready = 1'b0;
    repeat (3) tick();
    checks++; if (sel_valid !== 1'b0) begin errors++; $display("FAIL reset_sel_valid got=%b exp=0", sel_valid); end
    checks++; if (sel_active !== 1'b0) begin errors++; $display("FAIL reset_sel_active got=%b exp=0", sel_active); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (sel !== 3'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
    rst_n = 1'b1;
  endtask

  // Accept whatever is pending with code 0 and wait (bounded) for IDLE.
  task automatic go_idle();
    bit done;
    done = 1'b0;
    code_in = '0;
    sel_ready = 1'b1;
    for (int n = 0; n < 40 && !done; n++) begin
      tick();
      if (busy === 1'b0 && sel_valid === 1'b0 && sel_active === 1'b0) done = 1'b1;
    end
    sel_ready = 1'b0;
    checks++; if (!done) begin errors++; $display("FAIL go_idle_timeout busy=%b valid=%b active=%b exp idle", busy, sel_valid, sel_active); end
  endtask

  // Code 5 held: busy from t+2, sel_valid exactly at t+5.
  task automatic test_latency();
    logic exp_busy, exp_valid;
    code_in = 3'd5;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_busy  = (k >= 2);
      exp_valid = (k == 5);
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL latency_busy k=%0d got=%b exp=%b", k, busy, exp_busy); end
      checks++; if (sel_valid !== exp_valid) begin errors++; $display("FAIL latency_valid k=%0d got=%b exp=%b", k, sel_valid, exp_valid); end
    end
    checks++; if (sel !== 3'd5) begin errors++; $display("FAIL latency_sel got=%0d exp=5", sel); end
    go_idle();
  endtask

  // 5 for 2 cycles then 6 from u: offer of 6 exactly at u+5.
  task automatic test_restart();
    logic exp_valid;
    code_in = 3'd5;
    tick();
    tick();
    code_in = 3'd6;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_valid = (k == 5);
      checks++; if (sel_valid !== exp_valid) begin errors++; $display("FAIL restart_valid k=%0d got=%b exp=%b", k, sel_valid, exp_valid); end
    end
    checks++; if (sel !== 3'd6) begin errors++; $display("FAIL restart_sel got=%0d exp=6", sel); end
    go_idle();
  endtask

  // Short-lived request: back to IDLE, never offered, no drop.
  task automatic test_glitch();
    code_in = 3'd5;
    tick();
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_filter_busy got=%b exp=1", busy); end
    code_in = 3'd0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++; if (sel_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid k=%0d got=%b exp=0", k, sel_valid); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got=%b exp=0", busy); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL glitch_drop got=%0d exp=0", drop_cnt); end
  endtask

  // Stalled OFFER with toggling input, then an 8-cycle HOLD.
  task automatic test_offer_stall();
    code_in = 3'd3;
    repeat (5) tick();
    checks++; if (sel_valid !== 1'b1) begin errors++; $display("FAIL stall_offer got=%b exp=1", sel_valid); end
    for (int i = 0; i < 10; i++) begin
      code_in = (i % 2 == 0) ? 3'd7 : 3'd3;
      tick();
      checks++; if (sel_valid !== 1'b1) begin errors++; $display("FAIL stall_valid i=%0d got=%b exp=1", i, sel_valid); end
      checks++; if (sel !== 3'd3) begin errors++; $display("FAIL stall_sel i=%0d got=%0d exp=3", i, sel); end
      checks++; if (sel_active !== 1'b0) begin errors++; $display("FAIL stall_active i=%0d got=%b exp=0", i, sel_active); end
    end
    // Five 3->7 changes while offering; 7->3 matches sel and is not a drop.
    checks++; if (drop_cnt !== 8'd5) begin errors++; $display("FAIL stall_drop got=%0d exp=5", drop_cnt); end
    sel_ready = 1'b1;
    code_in = 3'd0;
    tick();
    sel_ready = 1'b0;
    checks++; if (sel_valid !== 1'b0) begin errors++; $display("FAIL hold_valid_low got=%b exp=0", sel_valid); end
    checks++; if (sel_active !== 1'b1) begin errors++; $display("FAIL hold_active c=1 got=%b exp=1", sel_active); end
    for (int k = 2; k <= 8; k++) begin
      tick();
      checks++; if (sel_active !== 1'b1) begin errors++; $display("FAIL hold_active c=%0d got=%b exp=1", k, sel_active); end
    end
    tick();
    checks++; if (sel_active !== 1'b0) begin errors++; $display("FAIL hold_end_active got=%b exp=0", sel_active); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_end_busy got=%b exp=0", busy); end
    checks++; if (sel !== 3'd3) begin errors++; $display("FAIL hold_end_sel got=%0d exp=3", sel); end
  endtask

  // Drops during HOLD, then saturation during a stalled OFFER.
  task automatic test_drop_saturate();
    bit found;
    code_in = 3'd5;
    repeat (5) tick();
    checks++; if (sel_valid !== 1'b1 || sel !== 3'd5) begin errors++; $display("FAIL drop_offer valid=%b sel=%0d exp 1/5", sel_valid, sel); end
    sel_ready = 1'b1;
    tick();
    sel_ready = 1'b0;
    code_in = 3'd3; tick();
    code_in = 3'd3; tick();
    code_in = 3'd6; tick();
    tick();
    checks++; if (sel_active !== 1'b1) begin errors++; $display("FAIL drop_in_hold got=%b exp=1", sel_active); end
    checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL drop_hold got=%0d exp=2", drop_cnt); end
    // Code 6 persists past HOLD and is re-armed.
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      tick();
      if (sel_valid === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rearm_timeout got valid=%b exp=1", sel_valid); end
    checks++; if (sel !== 3'd6) begin errors++; $display("FAIL rearm_sel got=%0d exp=6", sel); end
    for (int i = 0; i < 300; i++) begin
      code_in = (i % 2 == 1) ? 3'd2 : 3'd1;
      tick();
    end
    tick();
    tick();
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_saturate got=%0d exp=255", drop_cnt); end
    checks++; if (sel_valid !== 1'b1 || sel !== 3'd6) begin errors++; $display("FAIL saturate_offer valid=%b sel=%0d exp 1/6", sel_valid, sel); end
  endtask

  // Reset asserted between edges mid-HOLD clears outputs immediately.
  task automatic test_async_reset();
    logic exp_valid;
    code_in = 3'd0;
    sel_ready = 1'b1;
    tick();
    sel_ready = 1'b0;
    tick();
    tick();
    checks++; if (sel_active !== 1'b1) begin errors++; $display("FAIL areset_pre_active got=%b exp=1", sel_active); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (sel_active !== 1'b0) begin errors++; $display("FAIL areset_active got=%b exp=0", sel_active); end
    checks++; if (sel_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got=%b exp=0", sel_valid); end
    checks++; if (sel !== 3'd0) begin errors++; $display("FAIL areset_sel got=%0d exp=0", sel); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL areset_drop got=%0d exp=0", drop_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got=%b exp=0", busy); end
    code_in = 3'd2;
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_valid = (k == 5);
      checks++; if (sel_valid !== exp_valid) begin errors++; $display("FAIL areset_reoffer k=%0d got=%b exp=%b", k, sel_valid, exp_valid); end
    end
    checks++; if (sel !== 3'd2) begin errors++; $display("FAIL areset_reoffer_sel got=%0d exp=2", sel); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_restart();
    test_glitch();
    test_offer_stall();
    test_reset();
    test_drop_saturate();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
